ripple_borrow_subtractor_seq: RTL and testbench

// - Multi-cycle subtractor: diff = a - b - bin, computed CHUNK bits per cycle, LSB chunk first.
// - Borrow ripples between chunks through a register.
// - Inverse companion to the combinational ripple-carry adders.
// - Sits behind a valid/ready stream; trades latency for a narrow datapath of one CHUNK-bit subtractor.

---
 rtl/sub_pkg.sv | 16 +
 rtl/ripple_borrow_chunk.sv | 26 ++
 rtl/ripple_borrow_subtractor_seq.sv | 127 ++++++++++++
 tb/tb_ripple_borrow_subtractor_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared types and default geometry for the chunked ripple-borrow subtractor.
// NCHUNK and IDX_W describe the default build. The top derives its own values from its parameters.
package sub_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;
    localparam int NCHUNK    = DEF_WIDTH / DEF_CHUNK;
    localparam int IDX_W     = $clog2(NCHUNK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ripple_borrow_chunk.sv
// Combinational CHUNK-bit ripple-borrow subtractor built from per-bit full subtractors.
// msb_bin is the borrow into the top bit, so the caller can derive signed overflow.
module ripple_borrow_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] diff,
    output logic             bout,
    output logic             msb_bin
);

    logic [CHUNK:0] br;

    assign br[0] = bin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign diff[i]  = a[i] ^ b[i] ^ br[i];
        assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end

    assign bout    = br[CHUNK];
    assign msb_bin = br[CHUNK-1];

endmodule

// File: rtl/ripple_borrow_subtractor_seq.sv
// Multi-cycle subtractor: diff = a - b - bin, one CHUNK-bit slice per cycle, LSB slice first.
// Valid/ready on both sides: a transfer happens on a rising edge where valid and ready are both 1.
module ripple_borrow_subtractor_seq
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = $clog2(NCH);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_chunk, b_chunk, d_chunk;
    logic             c_bout, c_msb_bin;
    logic             accept;

    assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
    assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];

    ripple_borrow_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a       (a_chunk),
        .b       (b_chunk),
        .bin     (borrow_q),
        .diff    (d_chunk),
        .bout    (c_bout),
        .msb_bin (c_msb_bin)
    );

    // DONE passes out_ready through to in_ready, so a result hand-off and a new capture share one edge.
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        shadow_d = shadow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;

        case (state_q)
            RUN: begin
                // Partial slices collect in the shadow so diff never shows a mix of old and new results.
                shadow_d[idx_q*CHUNK +: CHUNK] = d_chunk;
                borrow_d = c_bout;
                idx_d    = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    diff_d  = shadow_d;
                    bout_d  = c_bout;
                    ovf_d   = c_msb_bin ^ c_bout;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready && !accept) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            a_d      = a;
            b_d      = b;
            borrow_d = bin;
            idx_d    = '0;
            state_d  = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            shadow_q <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            shadow_q <= shadow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_ripple_borrow_subtractor_seq.sv
// Scoreboard bench for ripple_borrow_subtractor_seq: directed corner cases, backpressure,
// reset mid-operation and randomized traffic against an arithmetic reference model.
module tb_ripple_borrow_subtractor_seq;

    localparam int W   = 32;
    localparam int NCH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         bin_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    logic [W+1:0] exp_q[$];
    int           acc_q[$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           bp_mode = 0;
    logic         prev_ov = 1'b0;

    ripple_borrow_subtractor_seq #(.WIDTH(W), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_in),
        .b         (b_in),
        .bin       (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain wide arithmetic, signed range test for overflow.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        logic [W:0] full;
        longint     sa, sb, sbi, r;
        logic       o;
        full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        sbi  = bi ? 64'sd1 : 64'sd0;
        r    = sa - sb - sbi;
        o    = (r < -64'sd2147483648) || (r > 64'sd2147483647);
        return {full[W-1:0], full[W], o};
    endfunction

    // out_ready driver: 0 = always ready, 1 = stalled, otherwise random.
    initial begin
        forever begin
            @(negedge clk);
            if (bp_mode == 0) out_ready = 1'b1;
            else if (bp_mode == 1) out_ready = 1'b0;
            else out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: checks latency on each rising out_valid and pops on each output handshake.
    initial begin
        logic [W+1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid && !prev_ov) begin
                    if (acc_q.size() == 0) check("latency_no_pending", 64'(out_valid), 64'(0));
                    else check("latency", 64'(cyc), 64'(acc_q[0] + NCH));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 64'(out_valid), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        void'(acc_q.pop_front());
                        check("diff", 64'(diff), 64'(e[W+1:2]));
                        check("bout", 64'(bout), 64'(e[1]));
                        check("ovf", 64'(ovf), 64'(e[0]));
                    end
                end
                prev_ov = out_valid;
            end
        end
    end

    task automatic present_and_accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                                      input logic [W+1:0] e);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        bin_in = bi;
        for (int t = 0; t < 60; t++) begin
            #1;
            if (in_ready) begin
                exp_q.push_back(e);
                acc_q.push_back(cyc + 1);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("accept_timeout", 64'(ok), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_in = $urandom;
        b_in = $urandom;
        bin_in = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        present_and_accept(a, b, bi, model(a, b, bi));
    endtask

    task automatic send_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                            input logic [W-1:0] ed, input logic eb, input logic eo);
        present_and_accept(a, b, bi, {ed, eb, eo});
    endtask

    task automatic drain();
        for (int t = 0; t < 300; t++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic wait_out_valid();
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("out_valid_timeout", 64'(seen), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         rbi;

        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_diff", 64'(diff), 64'(0));
        check("rst_bout", 64'(bout), 64'(0));
        check("rst_ovf", 64'(ovf), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", 64'(in_ready), 64'(1));

        bp_mode = 0;
        send_exp(32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        send_exp(32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send_exp(32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0);
        send_exp(32'h0100_0000, 32'h0000_0001, 1'b1, 32'h00FF_FFFE, 1'b0, 1'b0);
        send_exp(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        send_exp(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
        send_exp(32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        drain();

        // Backpressure: result held while stalled, new operand taken on release edge.
        bp_mode = 1;
        send(32'h1234_5678, 32'h1111_1111, 1'b0);
        wait_out_valid();
        in_valid = 1'b1;
        a_in = 32'hCAFE_0000;
        b_in = 32'h0000_BEEF;
        bin_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_diff_held", 64'(diff), 64'h0123_4567);
        end
        bp_mode = 0;
        @(negedge clk);
        #1;
        check("release_in_ready", 64'(in_ready), 64'(1));
        if (in_ready) begin
            exp_q.push_back(model(a_in, b_in, bin_in));
            acc_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Reset while the third slice is being computed.
        send(32'hDEAD_0000, 32'h0000_0001, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_diff", 64'(diff), 64'(0));
        check("midrst_bout", 64'(bout), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_in_ready", 64'(in_ready), 64'(1));
        send(32'h0000_1000, 32'h0000_0FFF, 1'b0);
        drain();

        // Random traffic with random output stalls.
        bp_mode = 2;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = $urandom; rb = ra; end
                2: begin ra = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF; rb = $urandom; end
                default: begin ra = $urandom_range(0, 300); rb = $urandom_range(0, 300); end
            endcase
            rbi = 1'($urandom_range(0, 1));
            send(ra, rb, rbi);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
